// File: rtl/ex_muldiv_stage.sv
// Iterative MIPS-style HI/LO multiply/divide unit for the EX stage (shift-add multiply, restoring divide).
// Optional build macro MD_EARLY_OUT_EN: zero-operand multiply and divide-by-zero complete at acceptance.
//
// state | meaning
// IDLE  | accepting new ops; MFHI/MFLO served combinationally
// CALC  | retiring BITS_PER_CYCLE quotient/product bits per cycle
// FIX   | sign correction and HI/LO write-back
module ex_muldiv_stage #(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [2:0]        i_md_op,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic              i_flush,
    output logic              o_stall,
    output logic [DATA_W-1:0] o_result,
    output logic              o_result_valid,
    output logic              o_busy,
    output logic              o_md_done,
    output logic              o_div_by_zero
);
    localparam int BPC   = BITS_PER_CYCLE;
    localparam int N     = DATA_W / BPC;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MFHI  = 3'b101;
    localparam logic [2:0] OP_MFLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]  acc_q, acc_d, wrk_q, wrk_d, opb_q, opb_d;
    logic               is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
    logic               dbz_q, dbz_d, done_q, done_d, dbz_out_q, dbz_out_d;

    logic               op_valid, is_mul_op, is_div_op, is_mf, is_signed;
    logic               accept, early_out, sa, sb;
    logic [DATA_W-1:0]  abs_a, abs_b;
    logic [DATA_W+BPC-1:0] mul_part;
    logic [DATA_W-1:0]  mul_hi_nx, mul_lo_nx, div_r_nx, div_q_nx;
    logic [DATA_W:0]    div_sh;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]  quo_fix, rem_fix;

    assign op_valid  = (i_md_op != 3'b000) && (i_md_op != 3'b111);
    assign is_mul_op = (i_md_op == OP_MULT) || (i_md_op == OP_MULTU);
    assign is_div_op = (i_md_op == OP_DIV) || (i_md_op == OP_DIVU);
    assign is_mf     = (i_md_op == OP_MFHI) || (i_md_op == OP_MFLO);
    assign is_signed = (i_md_op == OP_MULT) || (i_md_op == OP_DIV);
    // reset gates accept so no result is flagged valid while held in reset
    assign accept    = reset && i_start && !i_flush && op_valid && (state_q == IDLE);

    assign sa    = is_signed & i_rs_data[DATA_W-1];
    assign sb    = is_signed & i_rt_data[DATA_W-1];
    assign abs_a = sa ? -i_rs_data : i_rs_data;
    assign abs_b = sb ? -i_rt_data : i_rt_data;

`ifdef MD_EARLY_OUT_EN
    assign early_out = (is_mul_op && ((i_rs_data == '0) || (i_rt_data == '0)))
                    || (is_div_op && (i_rt_data == '0));
`else
    assign early_out = 1'b0;
`endif

    always_comb begin
        mul_part  = {{BPC{1'b0}}, acc_q}
                  + ({{BPC{1'b0}}, opb_q} * {{DATA_W{1'b0}}, wrk_q[BPC-1:0]});
        mul_hi_nx = mul_part[DATA_W+BPC-1:BPC];
        mul_lo_nx = {mul_part[BPC-1:0], wrk_q[DATA_W-1:BPC]};

        div_r_nx = acc_q;
        div_q_nx = wrk_q;
        div_sh   = '0;
        for (int i = 0; i < BPC; i++) begin
            div_sh   = {div_r_nx, div_q_nx[DATA_W-1]};
            div_q_nx = {div_q_nx[DATA_W-2:0], 1'b0};
            if (div_sh >= {1'b0, opb_q}) begin
                div_sh      = div_sh - {1'b0, opb_q};
                div_q_nx[0] = 1'b1;
            end
            div_r_nx = div_sh[DATA_W-1:0];
        end

        prod_fix = {acc_q, wrk_q};
        if (neg_q) prod_fix = -prod_fix;
        quo_fix = neg_q ? -wrk_q : wrk_q;
        rem_fix = rneg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        wrk_d     = wrk_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && (is_mul_op || is_div_op)) begin
                    if (early_out) begin
                        done_d = 1'b1;
                        if (is_div_op) begin
                            hi_d      = i_rs_data;
                            lo_d      = '1;
                            dbz_out_d = 1'b1;
                        end else begin
                            hi_d = '0;
                            lo_d = '0;
                        end
                    end else begin
                        state_d  = CALC;
                        cnt_d    = CNT_W'(N);
                        acc_d    = '0;
                        wrk_d    = abs_a;
                        opb_d    = abs_b;
                        is_div_d = is_div_op;
                        neg_d    = sa ^ sb;
                        rneg_d   = sa;
                        dbz_d    = is_div_op && (i_rt_data == '0);
                    end
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_r_nx : mul_hi_nx;
                wrk_d = is_div_q ? div_q_nx : mul_lo_nx;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // remainder of |a|/0 is |a|; the dividend-sign fix restores a itself
                    hi_d      = rem_fix;
                    lo_d      = dbz_q ? '1 : quo_fix;
                    dbz_out_d = dbz_q;
                end else begin
                    hi_d = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d = prod_fix[DATA_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            wrk_q     <= wrk_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign o_busy         = (state_q != IDLE);
    assign o_stall        = reset && i_start && !i_flush && op_valid && (state_q != IDLE);
    assign o_result_valid = accept && is_mf;
    assign o_result       = o_result_valid ? ((i_md_op == OP_MFHI) ? hi_q : lo_q) : '0;
    assign o_md_done      = done_q;
    assign o_div_by_zero  = dbz_out_q;
endmodule

// File: doc/ex_muldiv_stage.md
EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set operand, HI, LO and result width.
REQ-002 Parameter BITS_PER_CYCLE, default 1, SHALL set the bits retired per iteration; legal values are 1, 2 and 4, and each SHALL divide DATA_W exactly.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 i_start  in  1  SHALL mark a valid mult/div-class instruction in EX.
REQ-006 i_md_op  in  3  SHALL encode the operation: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO; 111 is reserved and treated as none.
REQ-007 i_rs_data, i_rt_data  in  DATA_W  SHALL carry the already-forwarded operands (rs = dividend/multiplicand).
REQ-008 i_flush  in  1  SHALL carry the mispredict kill for the EX instruction.
REQ-009 o_stall  out  1  SHALL hold IF/ID/EX.
REQ-010 o_result  out  DATA_W  SHALL carry the MFHI/MFLO data.
REQ-011 o_result_valid  out  1  SHALL qualify o_result.
REQ-012 o_busy  out  1  SHALL indicate that the unit is iterating.
REQ-013 o_md_done  out  1  SHALL pulse for one cycle when HI/LO update.
REQ-014 o_div_by_zero  out  1  SHALL pulse together with o_md_done for a DIV/DIVU whose divisor is 0.

Function
REQ-015 Accept SHALL occur when i_start & !i_flush & op!=none & state==IDLE; an instruction is never accepted while i_flush is high.
REQ-016 The FSM SHALL have the states IDLE, CALC and FIX.
- IDLE -> CALC on an accepted MULT/MULTU/DIV/DIVU.
- CALC -> FIX after N = DATA_W/BITS_PER_CYCLE iterations.
- FIX -> IDLE after one cycle.
REQ-017 In FIX the unit SHALL apply sign correction (signed ops only) and write HI/LO at the FIX edge; unsigned ops SHALL also pass through FIX so latency is uniform.
REQ-018 A mult/div accepted at edge k SHALL hold o_busy high for N+1 cycles, update HI/LO at edge k+N+1, and raise o_md_done during the cycle after that edge.
REQ-019 Issuing a MULT/DIV SHALL NOT stall the pipeline; only hazards stall it.
REQ-020 MFHI/MFLO accepted in IDLE SHALL drive o_result = HI/LO combinationally with o_result_valid=1 in the same cycle.
REQ-021 o_stall SHALL equal i_start & !i_flush & op!=none & state!=IDLE; a stalled op SHALL be accepted in the first IDLE cycle, so back-to-back ops are allowed.
REQ-022 MULT/MULTU SHALL place the 2*DATA_W-bit product with its high half in HI and its low half in LO.
REQ-023 DIV/DIVU SHALL place the quotient in LO and the remainder in HI; signed division truncates toward zero and the remainder takes the dividend's sign.
REQ-024 DIV of the most-negative value by -1 SHALL give LO = most-negative and HI = 0, with no flag.
REQ-025 Division by zero SHALL give HI = dividend and LO = all ones, and SHALL assert o_div_by_zero.
REQ-026 i_flush SHALL NOT abort an in-flight operation.
REQ-027 While not valid, o_result SHALL be 0.

Reset
REQ-028 reset low SHALL immediately force state=IDLE, HI=LO=0, iteration counter=0, and o_busy, o_stall, o_result_valid, o_md_done, o_div_by_zero and o_result all 0, including mid-CALC/FIX.
REQ-029 Any partial result SHALL be discarded on reset.

Configuration
REQ-030 With MD_EARLY_OUT_EN defined, a MULT/MULTU with either operand 0, or a DIV/DIVU with divisor 0, SHALL write HI/LO at the acceptance edge, never raise o_busy, and pulse o_md_done (and o_div_by_zero for divide) the next cycle.
REQ-031 Without MD_EARLY_OUT_EN, these cases SHALL take the full N+1-cycle path.

Verification
REQ-032 MULT 7 x 0xFFFFFFFD (DATA_W=32, BPC=1) -> o_busy high for 33 cycles, then MFLO=0xFFFFFFEB and MFHI=0xFFFFFFFF.
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; repeat with BPC=4 -> o_busy high for 9 cycles.
REQ-034 DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 DIVU 5 / 0 -> HI=5, LO=0xFFFFFFFF and o_div_by_zero pulse after 33 cycles without the macro, or 1 cycle later with MD_EARLY_OUT_EN.
REQ-036 MFHI issued 3 cycles after MULT -> o_stall high until o_busy drops, then o_result_valid with the new HI; MULT with i_flush=1 -> no state change.
REQ-037 Reset asserted mid-CALC -> o_busy=0 immediately, then MFHI=MFLO=0.
